alu_ctrl_seq: RTL and testbench

Control-step sequencer that drives the datapath strobes and the 5-bit `op_code` for the ALU. It fetches an instruction, then steps register-register, immediate, unary and mul/div ALU instructions through T0–T6, so operand A reaches Y and the result leaves Z. The ALU's opcode encoding is reused unchanged. The sequencer sits directly upstream of the ALU, Y, Z, HI and LO, and replaces hand-driven testbench control.

---
 rtl/alu_ctrl_seq.sv | 165 ++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// Control-step sequencer for the ALU datapath: fetch (T0-T2), then decode and execute (T3-T6).
// Optional fetch timeout in T1 is built when ALU_SEQ_FETCH_TIMEOUT_EN is defined.
module alu_ctrl_seq #(
  parameter int FETCH_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [4:0] ir_op,
  input  logic       mem_ready,
  output logic       pc_out,
  output logic       mar_in,
  output logic       inc_pc,
  output logic       z_in,
  output logic       zlow_out,
  output logic       zhigh_out,
  output logic       pc_in,
  output logic       mem_read,
  output logic       mdr_in,
  output logic       mdr_out,
  output logic       ir_in,
  output logic       gra,
  output logic       grb,
  output logic       grc,
  output logic       r_out,
  output logic       r_in,
  output logic       c_out,
  output logic       y_in,
  output logic       hi_in,
  output logic       lo_in,
  output logic [4:0] op_code,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_t;

  state_t state;
  logic   t1_first;
  logic   is_md, is_rr, is_imm, is_un, legal;
  logic   fetch_timeout;
  logic   to_pulse;

  assign dbg_state = state;

  always_comb begin
    is_md  = (ir_op == 5'b01111) || (ir_op == 5'b10000);
    is_rr  = ((ir_op >= 5'b00011) && (ir_op <= 5'b01011)) || is_md;
    is_imm = (ir_op >= 5'b01100) && (ir_op <= 5'b01110);
    is_un  = (ir_op == 5'b10001) || (ir_op == 5'b10010);
    legal  = is_rr || is_imm || is_un;
  end

`ifdef ALU_SEQ_FETCH_TIMEOUT_EN
  localparam int CW = (FETCH_WAIT_MAX > 1) ? $clog2(FETCH_WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(FETCH_WAIT_MAX - 1);
  logic [CW-1:0] wait_cnt;

  // Counts T1 cycles; cleared in T0 so each fetch starts from zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      to_pulse <= 1'b0;
    end else begin
      to_pulse <= 1'b0;
      if (state == S_T0) wait_cnt <= '0;
      else if (state == S_T1) begin
        wait_cnt <= wait_cnt + CW'(1);
        if (fetch_timeout) to_pulse <= 1'b1;
      end
    end
  end
  assign fetch_timeout = (state == S_T1) && !mem_ready && (wait_cnt == LAST);
`else
  localparam int unused_fetch_wait = FETCH_WAIT_MAX;
  assign fetch_timeout = 1'b0;
  assign to_pulse      = 1'b0;
`endif

  // start is only honoured in IDLE and the final state; mem_ready only in T1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      t1_first <= 1'b0;
    end else begin
      t1_first <= 1'b0;
      case (state)
        S_IDLE: if (start) state <= S_T0;
        S_T0: begin
          state    <= S_T1;
          t1_first <= 1'b1;
        end
        S_T1: begin
          if (mem_ready)          state <= S_T2;
          else if (fetch_timeout) state <= S_IDLE;
        end
        S_T2: state <= S_T3;
        S_T3: state <= legal ? S_T4 : S_IDLE;
        S_T4: state <= S_T5;
        S_T5: begin
          if (is_md)      state <= S_T6;
          else if (start) state <= S_T0;
          else            state <= S_IDLE;
        end
        S_T6:    state <= start ? S_T0 : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    {pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out, pc_in} = '0;
    {mem_read, mdr_in, mdr_out, ir_in}                        = '0;
    {gra, grb, grc, r_out, r_in, c_out, y_in, hi_in, lo_in}  = '0;
    op_code = 5'b00000;
    done    = 1'b0;
    illegal = to_pulse;
    busy    = (state != S_IDLE);
    case (state)
      S_T0: begin
        {pc_out, mar_in, inc_pc, z_in} = 4'b1111;
        op_code = 5'b00011;
      end
      S_T1: begin
        mem_read = 1'b1;
        mdr_in   = 1'b1;
        zlow_out = t1_first;
        pc_in    = t1_first;
      end
      S_T2: {mdr_out, ir_in} = 2'b11;
      S_T3: begin
        if (legal) {grb, r_out, y_in} = 3'b111;
        else       illegal = 1'b1;
      end
      S_T4: begin
        z_in = 1'b1;
        if (is_rr) begin
          {grc, r_out} = 2'b11;
          op_code = ir_op;
        end else if (is_imm) begin
          c_out = 1'b1;
          case (ir_op)
            5'b01100: op_code = 5'b00011;
            5'b01101: op_code = 5'b01010;
            default:  op_code = 5'b01011;
          endcase
        end else begin
          op_code = ir_op;
        end
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (is_md) lo_in = 1'b1;
        else       {gra, r_in, done} = 3'b111;
      end
      S_T6: {zhigh_out, hi_in, done} = 3'b111;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Randomized bench for alu_ctrl_seq: a per-cycle expected output word is built from the
// instruction list by a reference model and compared every cycle.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] ir_op = 5'd0;
  logic       mem_ready = 1'b0;
  logic pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out, pc_in;
  logic mem_read, mdr_in, mdr_out, ir_in;
  logic gra, grb, grc, r_out, r_in, c_out, y_in, hi_in, lo_in;
  logic [4:0] op_code;
  logic busy, done, illegal;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic [27:0] PC_OUT    = 28'd1 << 0;
  localparam logic [27:0] MAR_IN    = 28'd1 << 1;
  localparam logic [27:0] INC_PC    = 28'd1 << 2;
  localparam logic [27:0] Z_IN      = 28'd1 << 3;
  localparam logic [27:0] ZLOW_OUT  = 28'd1 << 4;
  localparam logic [27:0] ZHIGH_OUT = 28'd1 << 5;
  localparam logic [27:0] PC_IN     = 28'd1 << 6;
  localparam logic [27:0] MEM_READ  = 28'd1 << 7;
  localparam logic [27:0] MDR_IN    = 28'd1 << 8;
  localparam logic [27:0] MDR_OUT   = 28'd1 << 9;
  localparam logic [27:0] IR_IN     = 28'd1 << 10;
  localparam logic [27:0] GRA       = 28'd1 << 11;
  localparam logic [27:0] GRB       = 28'd1 << 12;
  localparam logic [27:0] GRC       = 28'd1 << 13;
  localparam logic [27:0] R_OUT     = 28'd1 << 14;
  localparam logic [27:0] R_IN      = 28'd1 << 15;
  localparam logic [27:0] C_OUT     = 28'd1 << 16;
  localparam logic [27:0] Y_IN      = 28'd1 << 17;
  localparam logic [27:0] HI_IN     = 28'd1 << 18;
  localparam logic [27:0] LO_IN     = 28'd1 << 19;
  localparam logic [27:0] BUSY      = 28'd1 << 20;
  localparam logic [27:0] DONE      = 28'd1 << 21;
  localparam logic [27:0] ILLEGAL   = 28'd1 << 22;

  logic [27:0] obs;
  assign obs = {op_code, illegal, done, busy, lo_in, hi_in, y_in, c_out, r_in, r_out,
                grc, grb, gra, ir_in, mdr_out, mdr_in, mem_read, pc_in, zhigh_out,
                zlow_out, z_in, inc_pc, mar_in, pc_out};

  alu_ctrl_seq #(.FETCH_WAIT_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ir_op(ir_op), .mem_ready(mem_ready),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in), .zlow_out(zlow_out),
    .zhigh_out(zhigh_out), .pc_in(pc_in), .mem_read(mem_read), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .ir_in(ir_in), .gra(gra), .grb(grb), .grc(grc), .r_out(r_out),
    .r_in(r_in), .c_out(c_out), .y_in(y_in), .hi_in(hi_in), .lo_in(lo_in),
    .op_code(op_code), .busy(busy), .done(done), .illegal(illegal), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard queues and per-cycle stimulus schedule
  logic [27:0] exp_q[$];
  logic        sch_start[$];
  logic        sch_ready[$];
  logic [4:0]  sch_ir[$];
  logic [4:0]  prog_ir[$];
  int          prog_st[$];
  logic        prog_b2b[$];
  int          rd_n;

  function automatic logic [27:0] opw(input logic [4:0] o);
    return {o, 23'd0};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction classes straight from the opcode table
  function automatic logic is_legal(input logic [4:0] ir);
    return (ir >= 5'd3) && (ir <= 5'd18);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] ir);
    return (ir == 5'd15) || (ir == 5'd16);
  endfunction

  function automatic logic [27:0] t4_word(input logic [4:0] ir);
    logic [27:0] w;
    w = Z_IN | BUSY;
    if ((ir <= 5'd11) || is_muldiv(ir)) w = w | GRC | R_OUT | opw(ir);
    else if (ir == 5'd12) w = w | C_OUT | opw(5'd3);
    else if (ir == 5'd13) w = w | C_OUT | opw(5'd10);
    else if (ir == 5'd14) w = w | C_OUT | opw(5'd11);
    else w = w | opw(ir);
    return w;
  endfunction

  // Latency from T0 to done (busy cycles), from the timing rules
  function automatic int exp_busy(input logic [4:0] ir, input int st);
    if (!is_legal(ir)) return 4 + st;
    return (is_muldiv(ir) ? 7 : 6) + st;
  endfunction

  task automatic push_cyc(input logic [27:0] e, input logic s, input logic r, input logic [4:0] ir);
    exp_q.push_back(e);
    sch_start.push_back(s);
    sch_ready.push_back(r);
    sch_ir.push_back(ir);
  endtask

  task automatic gen_instr(input logic [4:0] ir, input int stalls, input logic start_end);
    push_cyc(PC_OUT | MAR_IN | INC_PC | Z_IN | BUSY | opw(5'd3), rnd(), rnd(), ir);
    for (int j = 0; j <= stalls; j++)
      push_cyc(MEM_READ | MDR_IN | BUSY | ((j == 0) ? (ZLOW_OUT | PC_IN) : 28'd0),
               rnd(), (j == stalls), ir);
    push_cyc(MDR_OUT | IR_IN | BUSY, rnd(), rnd(), ir);
    if (!is_legal(ir)) begin
      push_cyc(ILLEGAL | BUSY, rnd(), rnd(), ir);
    end else begin
      push_cyc(GRB | R_OUT | Y_IN | BUSY, rnd(), rnd(), ir);
      push_cyc(t4_word(ir), rnd(), rnd(), ir);
      if (is_muldiv(ir)) begin
        push_cyc(ZLOW_OUT | LO_IN | BUSY, rnd(), rnd(), ir);
        push_cyc(ZHIGH_OUT | HI_IN | DONE | BUSY, start_end, rnd(), ir);
      end else begin
        push_cyc(ZLOW_OUT | GRA | R_IN | DONE | BUSY, start_end, rnd(), ir);
      end
    end
  endtask

  // driver + per-cycle compare: sample at negedge, then drive inputs for the next edge
  task automatic run_sched(input string tag, output int busy_n);
    int cyc;
    int nbus;
    logic [27:0] e;
    busy_n = 0;
    rd_n = 0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s cyc %0d: outputs got %h expected %h", tag, cyc, obs, e);
      end
      nbus = int'(pc_out) + int'(zlow_out) + int'(zhigh_out) + int'(mdr_out) + int'(r_out) + int'(c_out);
      checks++;
      if (nbus > 1) begin
        errors++;
        $display("FAIL %s bus_drivers cyc %0d: got %0d expected <=1", tag, cyc, nbus);
      end
      if (busy === 1'b1) busy_n++;
      if (mem_read === 1'b1) rd_n++;
      start     = sch_start.pop_front();
      mem_ready = sch_ready.pop_front();
      ir_op     = sch_ir.pop_front();
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic run_prog(input string tag, output int busy_n);
    int n;
    logic b;
    n = prog_ir.size();
    push_cyc(28'd0, 1'b1, rnd(), prog_ir[0]);
    for (int i = 0; i < n; i++) begin
      b = (i + 1 < n) && prog_b2b[i+1] && is_legal(prog_ir[i]);
      gen_instr(prog_ir[i], prog_st[i], b);
      if ((i + 1 < n) && !b) push_cyc(28'd0, 1'b1, rnd(), prog_ir[i+1]);
    end
    push_cyc(28'd0, 1'b0, rnd(), prog_ir[n-1]);
    push_cyc(28'd0, 1'b0, rnd(), prog_ir[n-1]);
    run_sched(tag, busy_n);
    prog_ir.delete();
    prog_st.delete();
    prog_b2b.delete();
  endtask

  task automatic single(input string tag, input logic [4:0] ir, input int st);
    int bn;
    prog_ir.push_back(ir);
    prog_st.push_back(st);
    prog_b2b.push_back(1'b0);
    run_prog(tag, bn);
    checks++;
    if (bn !== exp_busy(ir, st)) begin
      errors++;
      $display("FAIL %s latency op %0d: got %0d expected %0d", tag, ir, bn, exp_busy(ir, st));
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    start = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 28'd0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got %h expected 0", i, obs);
      end
    end
    reset_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 28'd0) begin
        errors++;
        $display("FAIL reset_release cyc %0d: got %h expected 0", i, obs);
      end
    end
  endtask

  task automatic test_add();
    single("add", 5'd3, 0);
  endtask

  task automatic test_reg_reg();
    for (int k = 0; k < 6; k++)
      single("reg_reg", 5'($urandom_range(3, 11)), int'($urandom_range(0, 2)));
  endtask

  task automatic test_immediate();
    single("addi", 5'd12, 0);
    single("andi", 5'd13, 0);
    single("ori", 5'd14, 1);
  endtask

  task automatic test_unary();
    single("neg", 5'd17, 0);
    single("not", 5'd18, 0);
  endtask

  task automatic test_muldiv();
    single("mul", 5'd15, 0);
    single("div", 5'd16, 2);
  endtask

  task automatic test_stall();
    single("add_stall", 5'd3, 3);
    checks++;
    if (rd_n !== 4) begin
      errors++;
      $display("FAIL stall_mem_read: got %0d cycles expected 4", rd_n);
    end
  endtask

  task automatic test_illegal();
    int v;
    single("illegal_1f", 5'd31, 0);
    for (int k = 0; k < 4; k++) begin
      v = int'($urandom_range(0, 15));
      single("illegal_rnd", (v < 3) ? 5'(v) : 5'(19 + v - 3), int'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    int bn;
    int exp_total;
    logic [4:0] ir;
    int st;
    exp_total = 0;
    for (int k = 0; k < 10; k++) begin
      ir = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(19, 31)) : 5'($urandom_range(3, 18));
      st = int'($urandom_range(0, 3));
      prog_ir.push_back(ir);
      prog_st.push_back(st);
      prog_b2b.push_back((k == 1) ? 1'b1 : rnd());
      exp_total += exp_busy(ir, st);
    end
    run_prog("back_to_back", bn);
    checks++;
    if (bn !== exp_total) begin
      errors++;
      $display("FAIL back_to_back_latency: got %0d expected %0d", bn, exp_total);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ir_op = 5'd3;
    start = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs !== (MEM_READ | MDR_IN | BUSY)) begin
      errors++;
      $display("FAIL reset_mid_stall: got %h expected %h", obs, MEM_READ | MDR_IN | BUSY);
    end
    reset_n = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 28'd0) begin
      errors++;
      $display("FAIL reset_mid_idle: got %h expected 0", obs);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 28'd0) begin
      errors++;
      $display("FAIL reset_mid_after: got %h expected 0", obs);
    end
  endtask

`ifdef ALU_SEQ_FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int bn;
    push_cyc(28'd0, 1'b1, 1'b0, 5'd3);
    push_cyc(PC_OUT | MAR_IN | INC_PC | Z_IN | BUSY | opw(5'd3), 1'b0, 1'b0, 5'd3);
    push_cyc(MEM_READ | MDR_IN | BUSY | ZLOW_OUT | PC_IN, 1'b0, 1'b0, 5'd3);
    for (int j = 0; j < 3; j++) push_cyc(MEM_READ | MDR_IN | BUSY, 1'b0, 1'b0, 5'd3);
    push_cyc(ILLEGAL, 1'b0, 1'b1, 5'd3);
    push_cyc(28'd0, 1'b0, 1'b1, 5'd3);
    run_sched("timeout", bn);
    checks++;
    if (bn !== 5) begin
      errors++;
      $display("FAIL timeout_busy: got %0d expected 5", bn);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_reg_reg();
    test_immediate();
    test_unary();
    test_muldiv();
    test_stall();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
`ifdef ALU_SEQ_FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
